// File: rtl/dip_pkg.sv
// Shared constants and types for the DIP switch debouncer.
package dip_pkg;

  localparam int DIP_WIDTH        = 8;
  localparam int DIP_TICK_DIV     = 12000;
  localparam int DIP_STABLE_TICKS = 8;

  // Per-bit qualification state: IDLE when the synchronised input matches
  // the debounced value, PENDING while a differing level is being qualified.
  typedef enum logic {
    BIT_IDLE    = 1'b0,
    BIT_PENDING = 1'b1
  } bit_state_t;

  // Width of the per-bit tick counter; it only ever reaches STABLE_TICKS-1.
  function automatic int dip_cnt_width(input int stable_ticks);
    return $clog2(stable_ticks + 1);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-FF synchroniser, tick-qualified counter and the debounced flop.
// commit is high in the cycle whose closing edge toggles stable_bit.
module debounce_bit
  import dip_pkg::*;
#(
  parameter int STABLE_TICKS = DIP_STABLE_TICKS,
  parameter int CNT_W        = dip_cnt_width(STABLE_TICKS)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       raw_bit,
  input  logic       tick,
  output logic       stable_bit,
  output logic       commit,
  output bit_state_t state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic             sync_a;
  logic             sync_b;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             stable_q;
  logic             stable_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= raw_bit;
      sync_b <= sync_a;
    end
  end

  // State register: counter and debounced value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt      <= cnt_nxt;
      stable_q <= stable_nxt;
    end
  end

  // A matching input in any cycle drops back to IDLE, so a bounce restarts qualification.
  always_comb begin
    cnt_nxt    = cnt;
    stable_nxt = stable_q;
    if (state == BIT_IDLE) begin
      cnt_nxt = '0;
    end else if (commit) begin
      cnt_nxt    = '0;
      stable_nxt = ~stable_q;
    end else if (tick) begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state      = (sync_b != stable_q) ? BIT_PENDING : BIT_IDLE;
    commit     = (state == BIT_PENDING) && tick && (cnt == CNT_LAST);
    stable_bit = stable_q;
  end

endmodule

// File: rtl/dip_debounce.sv
// DIP switch debouncer: shared sample-tick prescaler, WIDTH debounce_bit lanes,
// change strobe. Define DIP_DEBOUNCE_EDGE_EN to add per-bit rise/fall pulses.
module dip_debounce
  import dip_pkg::*;
#(
  parameter int WIDTH        = DIP_WIDTH,
  parameter int TICK_DIV     = DIP_TICK_DIV,
  parameter int STABLE_TICKS = DIP_STABLE_TICKS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable,
  output logic             changed,
`ifdef DIP_DEBOUNCE_EDGE_EN
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
`endif
  output logic [WIDTH-1:0] dbg_pending
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0]    presc;
  logic             tick;
  logic [WIDTH-1:0] commit;

  // Free-running: input activity never restarts the sample grid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  assign tick = (presc == PRESC_LAST);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    bit_state_t st;

    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw_bit   (raw[i]),
      .tick      (tick),
      .stable_bit(stable[i]),
      .commit    (commit[i]),
      .state     (st)
    );

    assign dbg_pending[i] = (st == BIT_PENDING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      changed <= 1'b0;
    end else begin
      changed <= |commit;
    end
  end

`ifdef DIP_DEBOUNCE_EDGE_EN
  // Committing bits toggle, so the new value is the inverse of the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise <= '0;
      fall <= '0;
    end else begin
      rise <= commit & ~stable;
      fall <= commit & stable;
    end
  end
`endif

endmodule
